// File: rtl/register_file_unit.sv
// 8x16 architectural register file with write-first bypass read ports and a
// per-register pending-write scoreboard that gates instruction issue.
module register_file_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int PEND_W  = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    output logic [15:0]       write_cnt
);

    localparam int          NREG     = 2 ** ADDR_W;
    localparam bit          R0_HARD  = (ZERO_R0 != 0);
    localparam [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];
    logic [15:0]       write_cnt_q, write_cnt_d;

    logic wr_en;
    logic iss_acc;

    // A hard-wired R0 swallows writes entirely: no data, no count.
    assign wr_en = wb_we && !(R0_HARD && wb_addr == '0);

    assign iss_ready = (R0_HARD && iss_rd == '0) ? 1'b1 : (pend_q[iss_rd] != PEND_MAX);
    assign iss_acc   = iss_valid && iss_ready && !(R0_HARD && iss_rd == '0);

    assign rs1_data = (R0_HARD && rs1_addr == '0) ? '0 :
                      (wb_we && wb_addr == rs1_addr) ? wb_data : regs_q[rs1_addr];
    assign rs2_data = (R0_HARD && rs2_addr == '0) ? '0 :
                      (wb_we && wb_addr == rs2_addr) ? wb_data : regs_q[rs2_addr];

    // The last outstanding write landing this cycle is served by the bypass.
    assign rs1_busy = (pend_q[rs1_addr] > PEND_ONE) ||
                      (pend_q[rs1_addr] == PEND_ONE && !(wb_we && wb_addr == rs1_addr));
    assign rs2_busy = (pend_q[rs2_addr] > PEND_ONE) ||
                      (pend_q[rs2_addr] == PEND_ONE && !(wb_we && wb_addr == rs2_addr));

    assign write_cnt = write_cnt_q;

    always_comb begin
        write_cnt_d = wr_en ? write_cnt_q + 16'd1 : write_cnt_q;
        for (int i = 0; i < NREG; i++) begin
            pend_d[i] = pend_q[i];
            if (iss_acc && iss_rd == ADDR_W'(i) && !(wb_we && wb_addr == ADDR_W'(i))) begin
                pend_d[i] = pend_q[i] + PEND_ONE;
            end else if (wb_we && wb_addr == ADDR_W'(i) && !(iss_acc && iss_rd == ADDR_W'(i))
                         && pend_q[i] != '0) begin
                pend_d[i] = pend_q[i] - PEND_ONE;
            end
        end
    end

    // NOTE: the register array is architecturally cleared on reset, so it is
    // built from flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
            write_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[wb_addr] <= wb_data;
            end
            for (int i = 0; i < NREG; i++) begin
                pend_q[i] <= pend_d[i];
            end
            write_cnt_q <= write_cnt_d;
        end
    end

endmodule
